// File: rtl/fir4_avg_post_if.sv
// Handshake bundle between the FIR sum source, the averaging post stage and its consumer.
interface fir4_avg_post_if #(
  parameter int unsigned w     = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [w+1:0]  sum_in;
  logic          sum_valid;
  logic          out_ready;
  logic          clr_ovf;
  logic [w-1:0]  avg_out;
  logic          out_valid;
  logic [LW-1:0] level;
  logic          warm;
  logic          ovf;

  // Post stage view
  modport slave (
    input  sum_in, sum_valid, out_ready, clr_ovf,
    output avg_out, out_valid, level, warm, ovf
  );

  // Producer/consumer view
  modport master (
    output sum_in, sum_valid, out_ready, clr_ovf,
    input  avg_out, out_valid, level, warm, ovf
  );
endinterface

// File: rtl/fir4_avg_post.sv
// Output stage for a 4-tap running-sum averaging FIR: scales sum/4, drops
// warm-up sums after reset and buffers averages in a small valid/ready FIFO.
// Build option FIR4_POST_ROUND_EN: round-half-up with saturation instead of truncation.
module fir4_avg_post #(
  parameter int unsigned w     = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SKIP  = 4
) (
  input  logic           clk,
  input  logic           reset,
  fir4_avg_post_if.slave bus
);
  localparam int unsigned PW        = $clog2(DEPTH);
  localparam int unsigned LW        = PW + 1;
  localparam int unsigned CW        = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int unsigned SKIP_LAST = (SKIP == 0) ? 0 : SKIP - 1;

  logic [w-1:0]  mem_q [DEPTH];
  logic [w-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] skip_q, skip_d;
  logic          warm_q, warm_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic [w-1:0]  avg_q, avg_d;

  logic [w-1:0]  avg_c;
  logic          pop_c, push_c, drop_c, full_c, push_req_c;

  // Sum to average conversion
`ifdef FIR4_POST_ROUND_EN
  logic [w+2:0] rnd_sum_c;
  logic [w+2:0] rnd_shr_c;
  always_comb begin
    rnd_sum_c = (w+3)'(bus.sum_in) + (w+3)'(2);
    rnd_shr_c = rnd_sum_c >> 2;
    if (rnd_shr_c > (w+3)'({w{1'b1}})) begin
      avg_c = {w{1'b1}};
    end else begin
      avg_c = rnd_shr_c[w-1:0];
    end
  end
`else
  always_comb begin
    avg_c = w'(bus.sum_in >> 2);
  end
`endif

  // Warm-up counting, FIFO push/pop, occupancy and overflow tracking
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    skip_d   = skip_q;
    warm_d   = warm_q;
    ovf_d    = ovf_q;

    full_c     = (level_q == LW'(DEPTH));
    pop_c      = valid_q && bus.out_ready;
    push_req_c = warm_q && bus.sum_valid;
    push_c     = push_req_c && (!full_c || pop_c);
    drop_c     = push_req_c && full_c && !pop_c;

    if (!warm_q && bus.sum_valid) begin
      if (skip_q == CW'(SKIP_LAST)) begin
        warm_d = 1'b1;
      end else begin
        skip_d = skip_q + CW'(1);
      end
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = avg_c;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end

    valid_d = (level_d != '0);
    avg_d   = mem_d[rd_ptr_d];
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      skip_q   <= '0;
      warm_q   <= 1'(SKIP == 0);
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      avg_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      skip_q   <= skip_d;
      warm_q   <= warm_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      avg_q    <= avg_d;
    end
  end

  assign bus.avg_out   = avg_q;
  assign bus.out_valid = valid_q;
  assign bus.level     = level_q;
  assign bus.warm      = warm_q;
  assign bus.ovf       = ovf_q;
endmodule
